// File: rtl/huffman_sched.sv
// Round-robin scheduler sharing one huffman core between two symbol sources, one frame per grant.
// Optional WAIT-state timeout abort is enabled by defining HUFF_SCHED_TIMEOUT_EN.

module huffman_sched #(
  parameter int unsigned FRAME_LEN = 100,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  src_data0,
  input  logic [7:0]  src_data1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        src_pop0,
  output logic        src_pop1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [47:0] res_cnt,
  output logic [47:0] res_hc,
  output logic [47:0] res_m,
  output logic        core_reset,
  output logic        core_gray_valid,
  output logic [7:0]  core_gray_data,
  input  logic        core_cnt_valid,
  input  logic        core_code_valid,
  input  logic [47:0] core_cnt,
  input  logic [47:0] core_hc,
  input  logic [47:0] core_m
);

  typedef enum logic [2:0] {IDLE, CRST, STREAM, WAIT, DONE} state_e;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        crst_q, crst_d;
  logic        cnt_seen_q, cnt_seen_d;
  logic        gv_q, gv_d;
  logic        err_q, err_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  pop_q, pop_d;
  logic [1:0]  done_q, done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  gd_q, gd_d;
  logic [47:0] rc_q, rc_d;
  logic [47:0] rh_q, rh_d;
  logic [47:0] rm_q, rm_d;
  logic        timeout_hit;
  logic        winner;

`ifdef HUFF_SCHED_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wcnt_q, wcnt_d;

  // Counts cycles spent in WAIT; zero everywhere else so each frame starts fresh.
  always_comb begin
    wcnt_d = (state_q == WAIT) ? wcnt_q + 16'd1 : 16'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wcnt_q <= 16'd0;
    else       wcnt_q <= wcnt_d;
  end

  assign timeout_hit = (wcnt_q == TO_LAST);
`else
  // TIMEOUT is at least 1, so this never fires; WAIT lasts until the core answers.
  assign timeout_hit = (TIMEOUT == 0);
`endif

  // Tie goes to the requester not served last.
  assign winner = (req0 & req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 | req1) state_d = CRST;
      CRST:    if (cnt_q == 8'd1) state_d = STREAM;
      STREAM:  if (cnt_q == LAST_IDX) state_d = WAIT;
      WAIT:    if (core_code_valid | timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    crst_d     = 1'b0;
    cnt_seen_d = cnt_seen_q;
    gv_d       = 1'b0;
    gd_d       = 8'd0;
    err_d      = err_q;
    gnt_d      = gnt_q;
    pop_d      = 2'b00;
    done_d     = 2'b00;
    cnt_d      = cnt_q;
    rc_d       = rc_q;
    rh_d       = rh_q;
    rm_d       = rm_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = winner;
          gnt_d   = winner ? 2'b10 : 2'b01;
          crst_d  = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      CRST: begin
        cnt_seen_d = 1'b0;
        if (cnt_q == 8'd0) begin
          crst_d = 1'b1;
          cnt_d  = 8'd1;
        end else begin
          cnt_d = 8'd0;
          pop_d = owner_q ? 2'b10 : 2'b01;
        end
      end
      STREAM: begin
        gv_d = 1'b1;
        gd_d = owner_q ? src_data1 : src_data0;
        if (cnt_q != LAST_IDX) begin
          cnt_d = cnt_q + 8'd1;
          pop_d = owner_q ? 2'b10 : 2'b01;
        end
      end
      WAIT: begin
        if (core_cnt_valid) begin
          rc_d       = core_cnt;
          cnt_seen_d = 1'b1;
        end
        if (core_code_valid) begin
          rh_d   = core_hc;
          rm_d   = core_m;
          err_d  = ~(cnt_seen_q | core_cnt_valid);
          done_d = owner_q ? 2'b10 : 2'b01;
        end else if (timeout_hit) begin
          rh_d   = 48'd0;
          rm_d   = 48'd0;
          err_d  = 1'b1;
          done_d = owner_q ? 2'b10 : 2'b01;
        end
      end
      DONE: begin
        last_d = owner_q;
        gnt_d  = 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      crst_q     <= 1'b0;
      cnt_seen_q <= 1'b0;
      gv_q       <= 1'b0;
      gd_q       <= 8'd0;
      err_q      <= 1'b0;
      gnt_q      <= 2'b00;
      pop_q      <= 2'b00;
      done_q     <= 2'b00;
      cnt_q      <= 8'd0;
      rc_q       <= 48'd0;
      rh_q       <= 48'd0;
      rm_q       <= 48'd0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      crst_q     <= crst_d;
      cnt_seen_q <= cnt_seen_d;
      gv_q       <= gv_d;
      gd_q       <= gd_d;
      err_q      <= err_d;
      gnt_q      <= gnt_d;
      pop_q      <= pop_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      rc_q       <= rc_d;
      rh_q       <= rh_d;
      rm_q       <= rm_d;
    end
  end

  assign gnt0            = gnt_q[0];
  assign gnt1            = gnt_q[1];
  assign src_pop0        = pop_q[0];
  assign src_pop1        = pop_q[1];
  assign done0           = done_q[0];
  assign done1           = done_q[1];
  assign err             = err_q;
  assign res_cnt         = rc_q;
  assign res_hc          = rh_q;
  assign res_m           = rm_q;
  assign core_reset      = reset | crst_q;
  assign core_gray_valid = gv_q;
  assign core_gray_data  = gd_q;

endmodule

// File: tb/tb_huffman_sched.sv
// Directed bench for huffman_sched: frame table, tie/back-to-back sequences, mid-frame reset, silent core.
// Honours HUFF_SCHED_TIMEOUT_EN for the silent-core case.

module tb_huffman_sched;

  localparam int unsigned FL = 100;
  localparam int unsigned TO = 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  src_data0, src_data1;
  logic        gnt0, gnt1, src_pop0, src_pop1, done0, done1, err;
  logic [47:0] res_cnt, res_hc, res_m;
  logic        core_reset, core_gray_valid;
  logic [7:0]  core_gray_data;
  logic        core_cnt_valid = 1'b0;
  logic        core_code_valid = 1'b0;
  logic [47:0] core_cnt, core_hc, core_m;

  always #5 clk = ~clk;

  huffman_sched #(.FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .src_data0(src_data0), .src_data1(src_data1),
    .gnt0(gnt0), .gnt1(gnt1), .src_pop0(src_pop0), .src_pop1(src_pop1),
    .done0(done0), .done1(done1), .err(err),
    .res_cnt(res_cnt), .res_hc(res_hc), .res_m(res_m),
    .core_reset(core_reset), .core_gray_valid(core_gray_valid), .core_gray_data(core_gray_data),
    .core_cnt_valid(core_cnt_valid), .core_code_valid(core_code_valid),
    .core_cnt(core_cnt), .core_hc(core_hc), .core_m(core_m)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Show-ahead sources with distinct symbol patterns.
  int idx0 = 0;
  int idx1 = 0;

  function automatic logic [7:0] pat(input int src, input int i);
    return (src == 0) ? 8'((i % 6) + 1) : 8'(6 - (i % 6));
  endfunction

  assign src_data0 = pat(0, idx0);
  assign src_data1 = pat(1, idx1);

  always @(posedge clk) begin
    if (src_pop0) idx0 <= idx0 + 1;
    if (src_pop1) idx1 <= idx1 + 1;
  end

  // Behavioural core: histogram of symbols 1..6; CNT_valid 5 and code_valid 9 cycles after the last symbol.
  logic        cnt_en = 1'b1;
  logic        code_en = 1'b1;
  logic [47:0] hc_v = 48'd0;
  logic [47:0] m_v = 48'd0;
  logic [7:0]  hist [1:6];
  int          dly = 0;

  always @(posedge clk) begin
    core_cnt_valid  <= 1'b0;
    core_code_valid <= 1'b0;
    if (core_reset) begin
      for (int k = 1; k <= 6; k++) hist[k] <= 8'd0;
      dly <= 0;
    end else begin
      if (core_gray_valid) begin
        if (core_gray_data >= 8'd1 && core_gray_data <= 8'd6)
          hist[int'(core_gray_data)] <= hist[int'(core_gray_data)] + 8'd1;
        dly <= 1;
      end else if (dly > 0 && dly < 20) begin
        dly <= dly + 1;
      end
      if (dly == 4 && cnt_en)  core_cnt_valid  <= 1'b1;
      if (dly == 8 && code_en) core_code_valid <= 1'b1;
    end
  end

  assign core_cnt = {hist[1], hist[2], hist[3], hist[4], hist[5], hist[6]};
  assign core_hc  = hc_v;
  assign core_m   = m_v;

  function automatic logic [47:0] exp_hist(input int src, input int base);
    logic [7:0] h [1:6];
    logic [7:0] s;
    for (int k = 1; k <= 6; k++) h[k] = 8'd0;
    for (int k = 0; k < int'(FL); k++) begin
      s = pat(src, base + k);
      h[int'(s)] = h[int'(s)] + 8'd1;
    end
    return {h[1], h[2], h[3], h[4], h[5], h[6]};
  endfunction

  typedef struct {
    logic r0, r1;        // requests applied at frame start
    logic k0, k1;        // requests left high after done
    logic cnt_en, code_en;
    logic own;           // expected owner
    logic err;           // expected err
  } vec_t;

  vec_t        vt [8];
  int          frame_no = 0;
  logic [47:0] exp_res_cnt = 48'd0;

  task automatic run_frame(input string tag, input vec_t v);
    int   base, waits, n_crst, n_pop_own, n_pop_oth, n_gv, n_gbad, t_pop1, t_gv1, t_gvl, t_done;
    logic got, done_seen, p_own, p_oth;
    logic [1:0] own_bits;
    frame_no++;
    hc_v    = 48'hA0B0_C0D0_E0F0 ^ 48'(frame_no);
    m_v     = 48'h1112_1314_1516 + 48'(frame_no);
    cnt_en  = v.cnt_en;
    code_en = v.code_en;
    own_bits = v.own ? 2'b10 : 2'b01;
    base = v.own ? idx1 : idx0;
    req0 = v.r0;
    req1 = v.r1;
    waits = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      waits++;
      if (gnt0 | gnt1) got = 1'b1;
    end
    check({tag, " gnt_latency"}, 64'(waits), 64'd1);
    check({tag, " gnt_owner"}, 64'({gnt1, gnt0}), 64'(own_bits));
    n_crst = 0; n_pop_own = 0; n_pop_oth = 0; n_gv = 0; n_gbad = 0;
    t_pop1 = -1; t_gv1 = -1; t_gvl = -1; t_done = -1; done_seen = 1'b0;
    for (int c = 0; c < int'(FL) + 100; c++) begin
      if (c > 0) @(negedge clk);
      p_own = v.own ? src_pop1 : src_pop0;
      p_oth = v.own ? src_pop0 : src_pop1;
      if (core_reset) n_crst++;
      if (p_own) begin n_pop_own++; if (t_pop1 < 0) t_pop1 = c; end
      if (p_oth) n_pop_oth++;
      if (core_gray_valid) begin n_gv++; if (t_gv1 < 0) t_gv1 = c; t_gvl = c; end
      if ({gnt1, gnt0} != own_bits) n_gbad++;
      if (done0 | done1) begin
        done_seen = 1'b1;
        t_done = c;
        break;
      end
    end
    check({tag, " done_seen"}, 64'(done_seen), 64'd1);
    if (v.cnt_en) exp_res_cnt = exp_hist(int'(v.own), base);
    check({tag, " done_owner"}, 64'({done1, done0}), 64'(own_bits));
    check({tag, " err"}, 64'(err), 64'(v.err));
    check({tag, " res_cnt"}, 64'(res_cnt), 64'(exp_res_cnt));
    check({tag, " res_hc"}, 64'(res_hc), 64'(hc_v));
    check({tag, " res_m"}, 64'(res_m), 64'(m_v));
    check({tag, " gnt_steady"}, 64'(n_gbad), 64'd0);
    check({tag, " core_reset_cycles"}, 64'(n_crst), 64'd2);
    check({tag, " pops_owner"}, 64'(n_pop_own), 64'(FL));
    check({tag, " pops_other"}, 64'(n_pop_oth), 64'd0);
    check({tag, " gray_valid_cycles"}, 64'(n_gv), 64'(FL));
    check({tag, " first_pop"}, 64'(t_pop1), 64'd2);
    check({tag, " first_gv"}, 64'(t_gv1), 64'd3);
    check({tag, " last_gv"}, 64'(t_gvl), 64'(FL + 2));
    check({tag, " done_time"}, 64'(t_done), 64'(FL + 12));
    @(negedge clk);
    check({tag, " gnt_after_done"}, 64'({gnt1, gnt0}), 64'd0);
    check({tag, " done_pulse_len"}, 64'({done1, done0}), 64'd0);
    req0 = v.k0;
    req1 = v.k1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_res_cnt = 48'd0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " ctl_outputs"}, 64'({gnt0, gnt1, src_pop0, src_pop1, done0, done1, err, core_gray_valid}), 64'd0);
    check({tag, " gray_data"}, 64'(core_gray_data), 64'd0);
    check({tag, " results"}, 64'(res_cnt | res_hc | res_m), 64'd0);
    check({tag, " core_reset"}, 64'(core_reset), 64'd1);
  endtask

  initial begin
    int   np, nd;
    vec_t v;
    logic got;

    //      r0    r1    k0    k1    cnt   code  own   err
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_core_reset", 64'(core_reset), 64'd0);

    for (int i = 0; i < 8; i++) run_frame($sformatf("vec%0d", i), vt[i]);

    // From reset, a tie goes to requester 0, then requester 1 after one idle cycle.
    do_reset();
    v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    run_frame("tie0", v);
    v = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    run_frame("tie1", v);

    // Reset asserted at pop 40 aborts the frame without a done pulse.
    frame_no++;
    cnt_en = 1'b1; code_en = 1'b1;
    req0 = 1'b1; req1 = 1'b0;
    np = 0;
    for (int i = 0; i < 200 && np < 40; i++) begin
      @(negedge clk);
      if (src_pop0) np++;
    end
    check("midreset_pops_reached", 64'(np), 64'd40);
    #1 reset = 1'b1;
    #1 check_cleared("midreset");
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (done0 | done1) nd++;
    end
    check("midreset_no_done", 64'(nd), 64'd0);
    reset = 1'b0;
    exp_res_cnt = 48'd0;
    v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    run_frame("after_reset", v);

    // Silent core: no CNT_valid and no code_valid.
    cnt_en = 1'b0; code_en = 1'b0;
    req0 = 1'b1; req1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1'b1;
    end
    check("silent_gnt", 64'(got), 64'd1);
    req0 = 1'b0;
    nd = 0;
`ifdef HUFF_SCHED_TIMEOUT_EN
    np = -1;
    for (int c = 1; c < int'(FL + TO) + 50 && np < 0; c++) begin
      @(negedge clk);
      if (done0) np = c;
    end
    check("timeout_done_time", 64'(np), 64'(FL + 2 + TO));
    check("timeout_err", 64'(err), 64'd1);
    check("timeout_res_hc", 64'(res_hc), 64'd0);
    check("timeout_res_m", 64'(res_m), 64'd0);
    check("timeout_res_cnt", 64'(res_cnt), 64'(exp_res_cnt));
`else
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done0 | done1) nd++;
    end
    check("silent_no_done", 64'(nd), 64'd0);
    check("silent_still_granted", 64'(gnt0), 64'd1);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_sched.md
# huffman_sched

Round-robin scheduler sharing one `huffman` core between two symbol sources. It grants the core to one requester at a time and resets the core before each frame. It then streams exactly `FRAME_LEN` symbols into `gray_valid`/`gray_data`, collects `CNT_valid` and `code_valid` results, and returns them to the granted requester with a one-cycle done pulse. It sits between the image-fetch front ends and the `huffman` core.

## Interface
- `FRAME_LEN`, 100: symbols per frame; 1..255.
- `TIMEOUT`, 1023: max cycles in WAIT before abort (only with the timeout macro); 1..65535.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  frame request, level; held until own done pulse.
- `src_data0`, `src_data1`  in  8  show-ahead symbol; must be valid whenever the matching pop is high.
- `gnt0`, `gnt1`  out  1  grant, registered; at most one high.
- `src_pop0`, `src_pop1`  out  1  registered; symbol consumed at this edge.
- `done0`, `done1`  out  1  one-cycle result pulse to owner.
- `err`  out  1  status of last frame, valid from done pulse until next done.
- `res_cnt`, `res_hc`, `res_m`  out  48  packed {X1..X6}, X1 in [47:40]; held until next done.
- `core_reset`  out  1  to core `reset`.
- `core_gray_valid`  out  1  to core `gray_valid`, registered.
- `core_gray_data`  out  8  to core `gray_data`, registered.
- `core_cnt_valid`, `core_code_valid`  in  1  from core.
- `core_cnt`, `core_hc`, `core_m`  in  48  core CNT1..6, HC1..6, M1..6, packed as above.

## Operation
- States: IDLE, CRST, STREAM, WAIT, DONE.
- IDLE → CRST when any req is high. Winner rule: if both requesters are high, the one not served last wins. `last` resets to 1, so requester 0 wins the first tie. The matching gnt rises at the same edge.
- CRST: 2 cycles, internal `crst` high; `core_reset = reset | crst`, combinational. The result capture flags are cleared. Then → STREAM.
- STREAM: the owner's pop is high for exactly FRAME_LEN consecutive cycles. A counter runs 0..FRAME_LEN-1, 8-bit, with no wrap past FRAME_LEN-1. Each pop edge registers `src_dataN` into `core_gray_data` and sets `core_gray_valid` to 1. After the last pop → WAIT.
- `core_gray_valid` / `core_gray_data` drop to 0 the cycle after the last pop.
- WAIT:
  - `core_cnt_valid` captures `core_cnt` into `res_cnt` and sets `cnt_seen`.
  - `core_code_valid` captures `core_hc`/`core_m`, sets `err = ~cnt_seen`, then → DONE.
  - If both valids are high in the same cycle, both are captured and `err = 0`.
  - Valids outside WAIT are ignored.
- DONE: 1 cycle. `doneN` for the owner is high; gnt is still high. `last` ← owner. At the next edge gnt drops and → IDLE. A new grant needs at least 1 IDLE cycle.
- A req dropped mid-frame is ignored; the frame completes and done still pulses.

## Timing
- Reset values: every output 0, except `core_reset` = 1 while `reset` is high. State is IDLE and `last` = 1.
- Reset mid-frame aborts immediately. No done pulse is issued and results are cleared.
- Latency from req high (sampled at edge E):
  - gnt at E.
  - core_reset for E..E+2.
  - first pop at E+2.
  - first `core_gray_valid` at E+3.
  - last `core_gray_valid` at E+2+FRAME_LEN.
- done timing: done is registered high the edge after the cycle in which `core_code_valid` is sampled.
- The counter of CNT/code latency is the core's responsibility. The scheduler imposes no lower bound.

## Configuration
- Macro: `HUFF_SCHED_TIMEOUT_EN`.
- Defined: a 16-bit WAIT counter is active. Reaching TIMEOUT cycles in WAIT without `core_code_valid` → DONE with `err = 1`; `res_hc`/`res_m` = 0 and `res_cnt` holds whatever was captured.
- Undefined: no counter, and WAIT lasts indefinitely. `err` arises only from a missing CNT_valid.

## Test plan
- req0 alone with 100 symbols (1..6 pattern) and a behavioural core answering with CNT_valid at +5 and code_valid at +9 → gnt0, core_reset 2 cycles, 100 pops, 100-cycle gray_valid, done0 one pulse, results equal the core values, err=0, gnt0 drops after done.
- req0 and req1 rise in the same cycle → gnt0 serves first, then gnt1 after 1 IDLE cycle; a second tie → gnt0 again, because last=1 after serving requester 1.
- req1 held continuously with req0 low → back-to-back requester-1 frames, each preceded by core_reset and separated by exactly 1 IDLE cycle.
- Core never asserts CNT_valid, code_valid at +9 → done pulse with err=1 and res_hc/res_m captured.
- With `HUFF_SCHED_TIMEOUT_EN`, TIMEOUT=50 and a silent core → done on WAIT cycle 50, err=1, res_hc=res_m=0. Without the macro, the scheduler stays in WAIT for 5000 cycles with no done.
- reset pulsed at pop 40 → all outputs 0 within the reset cycle and no done; after release, req0 restarts a full 100-pop frame.
